// File: rtl/alu_bitenum.sv
// Set-bit enumerator: emits the index of each set bit of a loaded word, one per beat,
// then pulses done with the beat count. Define ALU_BITENUM_MSB_FIRST_EN for MSB-first order.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// SCAN  | presenting the next set-bit index of rem
// DONE  | one-cycle done pulse, count valid
module alu_bitenum #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DATA_W),
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  pos;
    logic              single;

    // Priority encode of the registered word; the last match in loop order wins.
    always_comb begin
        pos = '0;
`ifdef ALU_BITENUM_MSB_FIRST_EN
        for (int i = 0; i < DATA_W; i++) begin
            if (rem_q[i]) pos = IDX_W'(i);
        end
`else
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (rem_q[i]) pos = IDX_W'(i);
        end
`endif
    end

    assign single = (rem_q != '0) && ((rem_q & (rem_q - DATA_W'(1))) == '0);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d   = in_data;
                    cnt_d   = '0;
                    state_d = (in_data != '0) ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                if (out_ready) begin
                    rem_d = rem_q & ~(DATA_W'(1) << pos);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (single) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt is cleared on load and frozen after DONE, so it doubles as the held count.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_SCAN);
    assign out_idx   = out_valid ? pos : '0;
    assign out_last  = out_valid && single;
    assign done      = (state_q == ST_DONE);
    assign count     = cnt_q;

endmodule

// File: tb/tb_alu_bitenum.sv
// Randomized bench for alu_bitenum against a queue-of-indices reference model.
// Honours ALU_BITENUM_MSB_FIRST_EN the same way the design does.
module tb_alu_bitenum;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              done;
    logic [CNT_W-1:0]  count;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    alu_bitenum #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat order: list of set-bit positions in scan order.
    task automatic build_exp(input logic [31:0] w);
        exp_q.delete();
        for (int b = 0; b < DATA_W; b++) begin
            if (w[b]) begin
`ifdef ALU_BITENUM_MSB_FIRST_EN
                exp_q.push_front(b);
`else
                exp_q.push_back(b);
`endif
            end
        end
    endtask

    // ready_pct 0..100 = handshake probability, 101 = alternate 1/0.
    // rst_after >= 0 asserts reset once that many beats have been accepted.
    task automatic run_word(input logic [31:0] w, input int ready_pct, input bit inject,
                            input int rst_after);
        int  n;
        int  beats;
        int  cyc;
        bit  fin;
        bit  rdy;
        bit  tog;
        build_exp(w);
        n = exp_q.size();
        beats = 0;
        cyc = 0;
        fin = 0;
        tog = 1;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (inject) begin
                in_valid = 1'b1;
                in_data  = 32'h1;
            end else begin
                in_valid = 1'b0;
            end
            if (rst_after >= 0 && beats == rst_after) begin
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", out_valid, 0);
                check("rst_done", done, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_count", count, 0);
                @(negedge clk);
                rst_n = 1'b1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("post_rst_done", done, 0);
                    check("post_rst_in_ready", in_ready, 1);
                    check("post_rst_valid", out_valid, 0);
                end
                return;
            end
            check("in_ready_busy", in_ready, 0);
            if (exp_q.size() == 0) begin
                check("done_pulse", done, 1);
                check("done_out_valid", out_valid, 0);
                check("done_count", count, n);
                check("beats_total", beats, n);
                fin = 1;
            end else begin
                check("early_done", done, 0);
                check("out_valid", out_valid, 1);
                check("out_idx", out_idx, exp_q[0]);
                check("out_last", out_last, (exp_q.size() == 1));
                if (ready_pct == 101) begin
                    rdy = tog;
                    tog = ~tog;
                end else begin
                    rdy = ($urandom_range(99) < ready_pct) || (cyc > 300);
                end
                out_ready = rdy;
                if (rdy) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            if (cyc > 500) begin
                check("timeout", 1, 0);
                fin = 1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after", in_ready, 1);
        check("done_once", done, 0);
        check("count_held", count, n);
    endtask

    initial begin
        logic [31:0] w;
        #2 rst_n = 1'b0;
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_out_last", out_last, 0);
        check("reset_done", done, 0);
        check("reset_count", count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_word(32'h0000_0000, 100, 0, -1);
        run_word(32'h8000_0011, 100, 0, -1);
        run_word(32'hFFFF_FFFF, 101, 0, -1);
        run_word(32'h0000_000C, 100, 1, -1);
        run_word(32'h0000_F000, 100, 0, 2);
        run_word(32'h0000_0001, 100, 0, -1);
        run_word(32'h8000_0000, 50, 0, -1);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(4))
                0: w = $urandom;
                1: w = $urandom & $urandom & $urandom;
                2: w = 32'h1 << $urandom_range(31);
                3: w = ~($urandom & $urandom);
                default: w = (t % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
            endcase
            run_word(w, $urandom_range(20, 100), bit'($urandom_range(1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
